// File: rtl/game_pkg.sv
// Shared definitions for the stop-the-counter game judge: state codes,
// score limits, the counter value type and the BCD score incrementer.
package game_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam int BCD_MAX   = 9;
  localparam int SCORE_MAX = 99;

  typedef logic [3:0] count_t;

  // Returns {tens, ones} after one point, holding at SCORE_MAX.
  function automatic logic [7:0] bcd_inc(input logic [3:0] tens, input logic [3:0] ones);
    logic [7:0] v;
    v = {tens, ones};
    if (int'(tens) * 10 + int'(ones) < SCORE_MAX) begin
      if (ones == 4'(BCD_MAX)) v = {tens + 4'd1, 4'd0};
      else                     v = {tens, ones + 4'd1};
    end
    return v;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge pulse
// for one asynchronous, bouncy push button.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_level;
  logic          r_level_d;
  logic [CW-1:0] r_cnt;

  // The flip lands on the edge where the count would reach DEBOUNCE_CYCLES.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= 1'b0;
      r_s2      <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_s1      <= raw;
      r_s2      <= r_s1;
      r_level_d <= r_level;
      if (r_s2 != r_level) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_level <= r_s2;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_level & ~r_level_d;

endmodule

// File: rtl/game_judge.sv
// Round sequencer: samples the game counter on a debounced stop press,
// judges hit/miss against TARGET and keeps BCD score and lives.
module game_judge
  import game_pkg::*;
#(
  parameter int unsigned TARGET          = 7,
  parameter int unsigned LIVES           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       start,
  input  logic [3:0] count_in,
  output logic [3:0] latched,
  output logic [3:0] score_tens,
  output logic [3:0] score_ones,
  output logic [2:0] lives_left,
  output logic       hit,
  output logic       miss,
  output logic       game_over,
  output logic [1:0] state_out
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

  logic          w_btn_level;
  logic          w_btn_rise;
  logic          w_press;
  logic [7:0]    w_score_next;

  logic          r_st1, r_st2, r_st3, r_go;
  count_t        r_c1, r_c2, r_c3, r_acc;
  logic [1:0]    r_state;
  logic [HW-1:0] r_hold;
  logic [3:0]    r_latched, r_tens, r_ones;
  logic [2:0]    r_lives;
  logic          r_hit, r_miss;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .raw   (btn_raw),
    .level (w_btn_level),
    .rise  (w_btn_rise)
  );

  assign w_press      = w_btn_rise & w_btn_level;
  assign w_score_next = bcd_inc(r_tens, r_ones);

  // Count bits may be caught mid-transition; only a value seen twice is trusted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st1 <= 1'b0;
      r_st2 <= 1'b0;
      r_st3 <= 1'b0;
      r_go  <= 1'b0;
      r_c1  <= '0;
      r_c2  <= '0;
      r_c3  <= '0;
      r_acc <= '0;
    end else begin
      r_st1 <= start;
      r_st2 <= r_st1;
      r_st3 <= r_st2;
      r_go  <= r_st2 & ~r_st3;
      r_c1  <= count_in;
      r_c2  <= r_c1;
      r_c3  <= r_c2;
      if (r_c2 == r_c3) r_acc <= r_c2;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_latched <= '0;
      r_tens    <= '0;
      r_ones    <= '0;
      r_lives   <= '0;
      r_hit     <= 1'b0;
      r_miss    <= 1'b0;
    end else begin
      r_hit  <= 1'b0;
      r_miss <= 1'b0;
      case (r_state)
        ST_IDLE, ST_OVER: begin
          if (r_go) begin
            r_tens  <= '0;
            r_ones  <= '0;
            r_lives <= LIVES[2:0];
            r_state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (w_press) begin
            r_latched <= r_acc;
            if (r_acc == TARGET[3:0]) begin
              r_hit  <= 1'b1;
              r_tens <= w_score_next[7:4];
              r_ones <= w_score_next[3:0];
            end else begin
              r_miss <= 1'b1;
              if (r_lives != '0) r_lives <= r_lives - 3'd1;
            end
            r_hold  <= '0;
            r_state <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (r_hold == HW'(HOLD_CYCLES - 1)) begin
            r_state <= (r_lives != '0) ? ST_PLAY : ST_OVER;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign latched    = r_latched;
  assign score_tens = r_tens;
  assign score_ones = r_ones;
  assign lives_left = r_lives;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign game_over  = (r_state == ST_OVER);
  assign state_out  = r_state;

endmodule
